// File: rtl/regression_evaluator_if.sv
// ---------------------------------------------------------------------------
// regression_evaluator_if
//
// Groups the two streaming handshakes of the regression evaluator:
//   sample stream  : s_valid, s_ready, s_x, s_y   (producer -> evaluator)
//   result stream  : r_valid, r_ready, r_yhat, r_res (evaluator -> consumer)
//
// Modports:
//   master : the environment side (drives samples, accepts results)
//   slave  : the evaluator side (accepts samples, drives results)
//
// Parameters:
//   DW : width of the unsigned sample fields s_x / s_y
//   RW : width of the signed result fields r_yhat / r_res
// ---------------------------------------------------------------------------
interface regression_evaluator_if #(
  parameter int DW = 20,
  parameter int RW = 32
);
  logic                 s_valid;
  logic                 s_ready;
  logic [DW-1:0]        s_x;
  logic [DW-1:0]        s_y;
  logic                 r_valid;
  logic                 r_ready;
  logic signed [RW-1:0] r_yhat;
  logic signed [RW-1:0] r_res;

  modport master (
    output s_valid, s_x, s_y, r_ready,
    input  s_ready, r_valid, r_yhat, r_res
  );

  modport slave (
    input  s_valid, s_x, s_y, r_ready,
    output s_ready, r_valid, r_yhat, r_res
  );
endinterface

// File: rtl/regression_evaluator.sv
// ---------------------------------------------------------------------------
// regression_evaluator
//
// Evaluates a finished linear fit y_hat = b0 + b1*x over a stream of samples.
// The coefficients are captured when a run starts; every accepted sample
// produces one result carrying the saturated prediction and the saturated
// residual y - y_hat. Optionally the sum of squared residuals is accumulated.
//
// Ports:
//   clk, rst  : clock; asynchronous active-high reset
//   start     : begin a run (only honoured in IDLE)
//   b0        : intercept, 84-bit two's complement integer
//   b1        : slope, 56-bit unsigned with FRAC fractional bits
//   bus       : slave side of regression_evaluator_if (sample in, result out)
//   busy      : high while loading, running or draining
//   done      : one-cycle pulse after the final result has been taken
//   sse       : sum of squared residuals, unsigned, saturating at 2^64-1
//
// Build option:
//   REG_EVAL_SSE_EN : when defined the squarer/accumulator is built and sse
//                     is live; otherwise sse is constant zero.
//
// Pipeline: S1 holds the raw product b1*x and y, S2 holds full-precision
// y_hat and residual, the result register holds the saturated values.
// A sample accepted at edge k is therefore visible as a result after k+2.
// A result that is valid but not taken freezes all three stages.
// ---------------------------------------------------------------------------
module regression_evaluator #(
  parameter int N_SAMPLES = 150,
  parameter int DW        = 20,
  parameter int FRAC      = 10,
  parameter int RW        = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [83:0]            b0,
  input  logic [55:0]            b1,
  regression_evaluator_if.slave  bus,
  output logic                   busy,
  output logic                   done,
  output logic [63:0]            sse
);

  localparam int B0W = 84;
  localparam int B1W = 56;
  localparam int PW  = B1W + DW;  // raw product width
  localparam int FW  = B0W + 2;   // full-precision prediction/residual width
  localparam int CW  = $clog2(N_SAMPLES + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t state_reg, state_next;

  logic [B0W-1:0]       b0_q;
  logic [B1W-1:0]       b1_q;
  logic [CW-1:0]        cnt_reg;

  logic                 s1_valid_reg;
  logic [PW-1:0]        s1_p_reg;
  logic [DW-1:0]        s1_y_reg;

  logic                 s2_valid_reg;
  logic signed [FW-1:0] s2_yhat_reg;
  logic signed [FW-1:0] s2_res_reg;

  logic                 r_valid_reg;
  logic signed [RW-1:0] r_yhat_reg;
  logic signed [RW-1:0] r_res_reg;

  logic                 stall;
  logic                 s_ready_int;
  logic                 accept;
  logic                 pipe_empty;
  logic [PW-1:0]        p_shr;
  logic signed [FW-1:0] yhat_full;
  logic signed [FW-1:0] res_full;

  // Clamp a full-precision signed value into the RW-bit signed range. The
  // value fits when every bit from the RW-1 position upward equals the sign.
  function automatic logic signed [RW-1:0] sat_rw(input logic signed [FW-1:0] v);
    logic [FW-RW:0] top;
    top = v[FW-1:RW-1];
    if ((&top) || (~|top))
      sat_rw = v[RW-1:0];
    else if (v[FW-1])
      sat_rw = {1'b1, {(RW-1){1'b0}}};
    else
      sat_rw = {1'b0, {(RW-1){1'b1}}};
  endfunction

  assign stall       = r_valid_reg && !bus.r_ready;
  // The count guard is redundant with the RUN->DRAIN transition but keeps
  // the counter from ever wrapping.
  assign s_ready_int = (state_reg == ST_RUN) && !stall && (cnt_reg < CW'(N_SAMPLES));
  assign accept      = bus.s_valid && s_ready_int;
  assign pipe_empty  = !s1_valid_reg && !s2_valid_reg;

  assign bus.s_ready = s_ready_int;
  assign bus.r_valid = r_valid_reg;
  assign bus.r_yhat  = r_yhat_reg;
  assign bus.r_res   = r_res_reg;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_reg <= ST_IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start)
          state_next = ST_LOAD;
      end
      ST_LOAD: begin
        busy       = 1'b1;
        state_next = ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (accept && (cnt_reg == CW'(N_SAMPLES - 1)))
          state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        // Leave once nothing is in flight and the result register is
        // either empty or being taken on this edge.
        if (pipe_empty && (!r_valid_reg || bus.r_ready))
          state_next = ST_DONE;
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // ------------------------------------------- coefficients and counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b0_q    <= '0;
      b1_q    <= '0;
      cnt_reg <= '0;
    end else begin
      // Captured when the run is accepted, so later input changes are
      // invisible until the next run.
      if ((state_reg == ST_IDLE) && start) begin
        b0_q <= b0;
        b1_q <= b1;
      end
      if (state_reg == ST_LOAD)
        cnt_reg <= '0;
      else if (accept)
        cnt_reg <= cnt_reg + CW'(1);
    end
  end

  // ------------------------------------------------------------ datapath
  assign p_shr     = s1_p_reg >> FRAC;
  assign yhat_full = $signed({{(FW-B0W){b0_q[B0W-1]}}, b0_q})
                   + $signed({{(FW-PW){1'b0}}, p_shr});
  assign res_full  = $signed({{(FW-DW){1'b0}}, s1_y_reg}) - yhat_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_p_reg     <= '0;
      s1_y_reg     <= '0;
      s2_valid_reg <= 1'b0;
      s2_yhat_reg  <= '0;
      s2_res_reg   <= '0;
      r_valid_reg  <= 1'b0;
      r_yhat_reg   <= '0;
      r_res_reg    <= '0;
    end else if (!stall) begin
      s1_valid_reg <= accept;
      if (accept) begin
        s1_p_reg <= {{DW{1'b0}}, b1_q} * {{B1W{1'b0}}, bus.s_x};
        s1_y_reg <= bus.s_y;
      end
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        s2_yhat_reg <= yhat_full;
        s2_res_reg  <= res_full;
      end
      r_valid_reg <= s2_valid_reg;
      // Data is only overwritten by a new result; it is left as-is when
      // the register empties.
      if (s2_valid_reg) begin
        r_yhat_reg <= sat_rw(s2_yhat_reg);
        r_res_reg  <= sat_rw(s2_res_reg);
      end
    end
  end

  // ------------------------------------------------- residual accumulator
`ifdef REG_EVAL_SSE_EN
  logic                     res_hs;
  logic signed [2*RW-1:0]   res_ext;
  logic signed [2*RW-1:0]   res_sq;
  logic [64:0]              sse_sum;
  logic [63:0]              sse_reg;

  assign res_hs  = r_valid_reg && bus.r_ready;
  assign res_ext = {{RW{r_res_reg[RW-1]}}, r_res_reg};
  assign res_sq  = res_ext * res_ext;
  // One extra bit catches the carry that signals saturation.
  assign sse_sum = {1'b0, sse_reg} + {{(65-2*RW){1'b0}}, res_sq};

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      sse_reg <= '0;
    else if (state_reg == ST_LOAD)
      sse_reg <= '0;
    else if (res_hs)
      sse_reg <= sse_sum[64] ? {64{1'b1}} : sse_sum[63:0];
  end

  assign sse = sse_reg;
`else
  assign sse = '0;
`endif

endmodule

// File: tb/tb_regression_evaluator.sv
// ---------------------------------------------------------------------------
// tb_regression_evaluator
//
// Directed runs of 150 samples with hand-computed results. The driver pushes
// the expected result of every accepted sample into a queue; an independent
// monitor pops and compares whenever a result is handshaken, and also checks
// hold-during-stall, the running sse and the done pulse.
// ---------------------------------------------------------------------------
module tb_regression_evaluator;
  localparam int N  = 150;
  localparam int DW = 20;
  localparam int RW = 32;
`ifdef REG_EVAL_SSE_EN
  localparam bit SSE_EN = 1'b1;
`else
  localparam bit SSE_EN = 1'b0;
`endif

  typedef struct {
    logic signed [31:0] yhat;
    logic signed [31:0] res;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic [83:0] b0;
  logic [55:0] b1;
  logic        busy;
  logic        done;
  logic [63:0] sse;

  regression_evaluator_if #(.DW(DW), .RW(RW)) bus();

  regression_evaluator #(
    .N_SAMPLES(N), .DW(DW), .FRAC(10), .RW(RW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .b0(b0), .b1(b1),
    .bus(bus), .busy(busy), .done(done), .sse(sse)
  );

  int          tests = 0;
  int          fails = 0;
  exp_t        sb_q[$];
  int          results = 0;
  int          done_cnt = 0;
  int          cycle = 0;
  int          last_hs_cycle = -10;
  logic [63:0] exp_sse = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ------------------------------------------------------------- monitor
  initial begin : monitor
    exp_t               e;
    logic signed [63:0] r64;
    logic [63:0]        sq;
    bit                 hs_prev = 1'b0;
    bit                 stall_prev = 1'b0;
    logic [31:0]        held_yhat = '0;
    logic [31:0]        held_res = '0;
    forever begin
      @(negedge clk);
      cycle++;
      if (rst) begin
        hs_prev    = 1'b0;
        stall_prev = 1'b0;
      end else begin
        if (hs_prev)
          check("sse_running", sse, SSE_EN ? exp_sse : 64'd0);
        if (stall_prev) begin
          check("hold_valid", 64'(bus.r_valid), 64'd1);
          check("hold_yhat", 64'(bus.r_yhat), 64'(held_yhat));
          check("hold_res", 64'(bus.r_res), 64'(held_res));
        end
        hs_prev    = 1'b0;
        stall_prev = 1'b0;
        if (bus.r_valid && bus.r_ready) begin
          if (sb_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_result: got yhat=%0d res=%0d, expected no result",
                     bus.r_yhat, bus.r_res);
          end else begin
            e = sb_q.pop_front();
            check("yhat", 64'(bus.r_yhat), 64'(e.yhat));
            check("res", 64'(bus.r_res), 64'(e.res));
            $display("[TB] result %0d yhat=%0d res=%0d", results, bus.r_yhat, bus.r_res);
            r64 = 64'(e.res);
            sq  = r64 * r64;
            if (exp_sse + sq < exp_sse)
              exp_sse = {64{1'b1}};
            else
              exp_sse = exp_sse + sq;
          end
          results++;
          last_hs_cycle = cycle;
          hs_prev = 1'b1;
        end else if (bus.r_valid) begin
          check("stall_s_ready", 64'(bus.s_ready), 64'd0);
          held_yhat  = bus.r_yhat;
          held_res   = bus.r_res;
          stall_prev = 1'b1;
        end
        if (done) begin
          done_cnt++;
          check("done_after_last_hs", 64'(cycle), 64'(last_hs_cycle + 1));
          check("done_result_count", 64'(results), 64'(N));
          check("done_sse", sse, SSE_EN ? exp_sse : 64'd0);
        end
      end
    end
  end

  // ------------------------------------------------------------- driver
  task automatic send(input logic [19:0] x, input logic [19:0] y,
                      input logic [31:0] ey, input logic [31:0] er, output bit ok);
    exp_t e;
    ok = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_x     = x;
    bus.s_y     = y;
    for (int w = 0; w < 100; w++) begin
      @(negedge clk);
      if (bus.s_ready) begin
        @(posedge clk);
        #1;
        e.yhat = ey;
        e.res  = er;
        sb_q.push_back(e);
        ok = 1'b1;
        break;
      end
    end
    bus.s_valid = 1'b0;
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: got s_ready=0 for 100 cycles, expected 1");
    end
  endtask

  // kind 0: x=10 y=30 ; kind 1: x=7/8 y=0 ; kind 2: x=i y=2i+3 ; kind 3: x=y=0
  task automatic do_run(input int kind, input logic [83:0] b0v, input logic [55:0] b1v,
                        input int n_send, input int bp_at, input logic [63:0] sse_final);
    int          first_c;
    int          last_c;
    bit          ok;
    logic [19:0] x;
    logic [19:0] y;
    logic [31:0] ey;
    logic [31:0] er;
    first_c = 0;
    last_c  = 0;
    exp_sse = '0;
    results = 0;
    done_cnt = 0;
    last_hs_cycle = -10;
    b0 = b0v;
    b1 = b1v;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("load_busy", 64'(busy), 64'd1);
    @(posedge clk);
    #1;
    // Coefficient inputs change after the run has begun; must be ignored.
    b0 = 84'h123456;
    b1 = 56'd77;
    for (int i = 0; i < n_send; i++) begin
      case (kind)
        0: begin x = 20'd10; y = 20'd30; ey = 32'd25; er = 32'd5; end
        1: begin
          x  = (i % 2 == 0) ? 20'd7 : 20'd8;
          y  = 20'd0;
          ey = (i % 2 == 0) ? 32'd10 : 32'd12;
          er = (i % 2 == 0) ? -32'sd10 : -32'sd12;
        end
        2: begin x = 20'(i); y = 20'(2 * i + 3); ey = 32'(2 * i + 3); er = 32'd0; end
        default: begin x = 20'd0; y = 20'd0; ey = 32'h8000_0000; er = 32'h7FFF_FFFF; end
      endcase
      if (i == bp_at) begin
        fork
          begin
            bus.r_ready = 1'b0;
            repeat (5) @(posedge clk);
            #1 bus.r_ready = 1'b1;
          end
        join_none
      end
      if (kind == 2 && i == 20) start = 1'b1;
      if (kind == 2 && i == 21) start = 1'b0;
      send(x, y, ey, er, ok);
      if (!ok) return;
      if (i == 0) begin
        first_c = cycle;
        fork
          begin
            @(posedge clk);
            #2 check("latency_k1_rvalid", 64'(bus.r_valid), 64'd0);
            @(posedge clk);
            #2 check("latency_k2_rvalid", 64'(bus.r_valid), 64'd1);
          end
        join_none
      end
      last_c = cycle;
    end
    if (n_send < N) return;
    if (kind == 0)
      check("throughput", 64'(last_c - first_c), 64'(N - 1));
    for (int w = 0; w < 50 && done_cnt == 0; w++)
      @(posedge clk);
    if (done_cnt == 0) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: got no done within 50 cycles, expected a pulse");
    end
    repeat (4) @(posedge clk);
    #1;
    check("done_once", 64'(done_cnt), 64'd1);
    check("result_count", 64'(results), 64'(N));
    check("sb_empty", 64'(sb_q.size()), 64'd0);
    check("sse_final", sse, SSE_EN ? sse_final : 64'd0);
    check("idle_busy", 64'(busy), 64'd0);
    $display("[TB] run kind=%0d complete, results=%0d sse=0x%0h", kind, results, sse);
  endtask

  // ------------------------------------------------------------- main
  initial begin
    rst         = 1'b1;
    start       = 1'b1;   // start together with reset must be ignored
    b0          = '0;
    b1          = '0;
    bus.s_valid = 1'b0;
    bus.s_x     = '0;
    bus.s_y     = '0;
    bus.r_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rvalid", 64'(bus.r_valid), 64'd0);
    check("rst_yhat", 64'(bus.r_yhat), 64'd0);
    check("rst_res", 64'(bus.r_res), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_sse", sse, 64'd0);
    rst   = 1'b0;
    start = 1'b0;
    @(posedge clk);
    #1;
    check("start_with_rst_ignored", 64'(busy), 64'd0);

    // s_valid in IDLE is never accepted
    bus.s_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle_s_ready", 64'(bus.s_ready), 64'd0);
    end
    bus.s_valid = 1'b0;
    @(posedge clk);
    #1;
    check("idle_no_result", 64'(bus.r_valid), 64'd0);

    // b0=5, b1=2.0, x=10, y=30 -> 25 / 5 ; sse = 150*25
    do_run(0, 84'd5, 56'd2048, N, -1, 64'd3750);
    // b0=0, b1=1.5, x=7 -> 10 / -10 ; x=8 -> 12 / -12 ; sse = 75*100 + 75*144
    do_run(1, 84'd0, 56'd1536, N, -1, 64'd18300);
    // exact fit with a 5-cycle result stall in the middle
    do_run(2, 84'd3, 56'd2048, N, 75, 64'd0);
    // b0 = -2^40 saturates both outputs; sse saturates at 2^64-1
    do_run(3, (~(84'd1 << 40)) + 84'd1, 56'd2048, N, -1, {64{1'b1}});

    // reset after 60 samples of a run with nonzero residuals
    do_run(0, 84'd5, 56'd2048, 60, -1, 64'd0);
    #1 rst = 1'b1;
    #2;
    check("midrst_rvalid", 64'(bus.r_valid), 64'd0);
    check("midrst_yhat", 64'(bus.r_yhat), 64'd0);
    check("midrst_res", 64'(bus.r_res), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_s_ready", 64'(bus.s_ready), 64'd0);
    check("midrst_sse", sse, 64'd0);
    sb_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_idle", 64'(busy), 64'd0);
    // fresh run: sse covers only this run
    do_run(2, 84'd3, 56'd2048, N, -1, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
